// File: rtl/miriscv_data_mem_responder_if.sv
// Data-port bundle between the miriscv core (master) and the memory responder (slave).
// req qualifies we/be/addr/wdata; there is no ready, so every cycle with req high is a request.
// rvalid pulses once per request, a fixed number of cycles later, in order; rdata/err are 0 otherwise.
interface miriscv_data_mem_responder_if;
  logic        data_req_i;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_wdata_i;
  logic        data_rvalid_o;
  logic [31:0] data_rdata_o;
  logic        busy_o;
  logic        err_o;

  modport master (
    output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    input  data_rvalid_o, data_rdata_o, busy_o, err_o
  );

  modport slave (
    input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    output data_rvalid_o, data_rdata_o, busy_o, err_o
  );
endinterface

// File: rtl/miriscv_data_mem_responder.sv
// Word-addressed RAM behind the miriscv data port with a fixed-latency in-order response pipeline.
// Optional macro MIRISCV_DMEM_BOUND_CHECK_EN: drop out-of-range stores, answer out-of-range loads with 32'hDEAD_BEEF and err_o.
module miriscv_data_mem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic                          clk_i,
  input  logic                          arst_i,
  miriscv_data_mem_responder_if.slave   bus
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  logic [31:0]      offset;
  logic [IDX_W-1:0] idx;
  logic             rst_hold;
  logic             accept;
  logic             wr_en;
  logic [31:0]      rd_word;
  logic [31:0]      resp_rdata;
  logic             resp_err;
  logic             unused_bits;

  logic [31:0] mem [DEPTH_WORDS];

  logic [LATENCY-1:0] pipe_valid;
  logic [LATENCY-1:0] pipe_err;
  logic [31:0]        pipe_rdata [LATENCY];

  assign offset = bus.data_addr_i - BASE_ADDR;
  assign idx    = offset[IDX_W+1:2];

  // rst_hold stays high through the reset-release cycle so a request there is ignored.
  assign accept = bus.data_req_i & ~rst_hold;

`ifdef MIRISCV_DMEM_BOUND_CHECK_EN
  logic in_range;
  assign in_range    = (offset[31:IDX_W+2] == '0);
  assign wr_en       = accept & bus.data_we_i & in_range;
  assign rd_word     = in_range ? mem[idx] : 32'hDEAD_BEEF;
  assign resp_err    = accept & ~in_range;
  assign unused_bits = ^offset[1:0];
`else
  assign wr_en       = accept & bus.data_we_i;
  assign rd_word     = mem[idx];
  assign resp_err    = 1'b0;
  assign unused_bits = ^{offset[31:IDX_W+2], offset[1:0]};
`endif

  assign resp_rdata = (accept & ~bus.data_we_i) ? rd_word : 32'h0;

  // RAM contents survive reset.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.data_be_i[b]) begin
          mem[idx][8*b +: 8] <= bus.data_wdata_i[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      rst_hold   <= 1'b1;
      pipe_valid <= '0;
      pipe_err   <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        pipe_rdata[i] <= '0;
      end
    end else begin
      rst_hold      <= 1'b0;
      pipe_valid[0] <= accept;
      pipe_err[0]   <= resp_err;
      pipe_rdata[0] <= resp_rdata;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_err[i]   <= pipe_err[i-1];
        pipe_rdata[i] <= pipe_rdata[i-1];
      end
    end
  end

  // Idle stages carry zero data/err, so the outputs are 0 whenever rvalid is low.
  assign bus.data_rvalid_o = pipe_valid[LATENCY-1];
  assign bus.data_rdata_o  = pipe_rdata[LATENCY-1];
  assign bus.err_o         = pipe_err[LATENCY-1];
  assign bus.busy_o        = |pipe_valid;

endmodule
